// File: rtl/idli_decode.sv
// idli_decode: assembles SQI nibbles into a decoded instruction plus optional immediate
package idli_pkg;
   localparam logic [2:0] GREG_PC = 3'd7;
   typedef enum logic [1:0] {ALU_ADD, ALU_AND, ALU_OR, ALU_XOR} alu_op_t;
   typedef struct packed {
      logic [1:0] op_p;
      alu_op_t    alu_op;
      logic [2:0] op_a;
      logic [2:0] op_b;
      logic [2:0] op_c;
      logic [1:0] op_q;
      logic       op_a_wr_en;
      logic       op_q_wr_en;
      logic       op_c_imm;
   } instr_t;
endpackage

module idli_decode
   import idli_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_nib_vld,
   input  logic [3:0]  i_nib,
   output logic        o_nib_rdy,
   input  logic        i_flush,
   output logic        o_instr_vld,
   input  logic        i_instr_rdy,
   output instr_t      o_instr,
   output logic [15:0] o_imm
);
   localparam logic [1:0] ST_INSTR = 2'd0;
   localparam logic [1:0] ST_IMM   = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;
   logic [1:0]  state_q, state_d, cnt_q, cnt_d;
   logic [15:0] w_q, w_d, imm_q, imm_d, w_nxt;
   logic        acc;
   instr_t      dec;
   assign o_nib_rdy   = state_q != ST_HOLD;
   assign o_instr_vld = state_q == ST_HOLD;
   assign acc         = i_nib_vld && o_nib_rdy;
   assign w_nxt       = {w_q[11:0], i_nib};
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      w_d     = w_q;
      imm_d   = imm_q;
      if (i_flush) begin
         state_d = ST_INSTR;
         cnt_d   = 2'd0;
         imm_d   = 16'd0;
      end else if (state_q == ST_HOLD) begin
         if (i_instr_rdy) begin
            state_d = ST_INSTR;
            cnt_d   = 2'd0;
            imm_d   = 16'd0;
         end
      end else if (acc) begin
         cnt_d = cnt_q + 2'd1;
         if (state_q == ST_INSTR) w_d = w_nxt;
         else imm_d = {imm_q[11:0], i_nib};
         // completing nibble: C field of the finished word decides whether an immediate follows
         if (cnt_q == 2'd3)
            state_d = (state_q == ST_INSTR && w_nxt[5:3] == GREG_PC) ? ST_IMM : ST_HOLD;
      end
   end
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= ST_INSTR;
         cnt_q   <= 2'd0;
         w_q     <= 16'd0;
         imm_q   <= 16'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         w_q     <= w_d;
         imm_q   <= imm_d;
      end
   end
   always_comb begin
      dec.op_p       = w_q[15:14];
      dec.alu_op     = alu_op_t'(w_q[13:12]);
      dec.op_a       = w_q[11:9];
      dec.op_b       = w_q[8:6];
      dec.op_c       = w_q[5:3];
      dec.op_q       = w_q[2:1];
      dec.op_a_wr_en = ~w_q[0];
      dec.op_q_wr_en = w_q[0];
      dec.op_c_imm   = w_q[5:3] == GREG_PC;
   end
   // outputs read as zero whenever nothing is held
   assign o_instr = o_instr_vld ? dec : '0;
   assign o_imm   = (o_instr_vld && dec.op_c_imm) ? imm_q : 16'd0;
endmodule

// File: tb/tb_idli_decode.sv
// tb_idli_decode: directed and gapped-random checks of idli_decode against a scoreboard
module tb_idli_decode;
   import idli_pkg::*;
   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_nib_vld = 1'b0;
   logic [3:0]  i_nib = 4'd0;
   logic        o_nib_rdy;
   logic        i_flush = 1'b0;
   logic        o_instr_vld;
   logic        i_instr_rdy = 1'b0;
   instr_t      o_instr;
   logic [15:0] o_imm;

   typedef struct packed {
      logic [17:0] instr;
      logic [15:0] imm;
   } exp_t;

   localparam logic [17:0] K1234 = 18'b00_01_001_000_110_10_1_0_0;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   hs = 0;
   int   pushed = 0;

   idli_decode dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_nib_vld(i_nib_vld), .i_nib(i_nib),
      .o_nib_rdy(o_nib_rdy), .i_flush(i_flush), .o_instr_vld(o_instr_vld),
      .i_instr_rdy(i_instr_rdy), .o_instr(o_instr), .o_imm(o_imm)
   );

   always #5 i_clk = ~i_clk;

   function automatic instr_t model(input logic [15:0] w);
      instr_t r;
      r.op_p       = w[15:14];
      r.alu_op     = alu_op_t'(w[13:12]);
      r.op_a       = w[11:9];
      r.op_b       = w[8:6];
      r.op_c       = w[5:3];
      r.op_q       = w[2:1];
      r.op_a_wr_en = !w[0];
      r.op_q_wr_en = w[0];
      r.op_c_imm   = w[5:3] == 3'd7;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      exp_t e;
      @(negedge i_clk);
      if (o_instr_vld && i_instr_rdy && !i_flush && i_rst_n) begin
         total++;
         assert (sb.size() > 0) else begin
            bad++;
            $error("FAIL sb_extra observed=%h expected=empty-handshake", o_instr);
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            hs++;
            chk("sb_instr", 32'(o_instr), 32'(e.instr));
            chk("sb_imm", 32'(o_imm), 32'(e.imm));
         end
      end
      @(posedge i_clk);
      #1;
   endtask

   task automatic put(input logic [3:0] n, input bit rnd);
      int k = 0;
      while (rnd && (!o_nib_rdy || $urandom_range(0, 2) == 0) && k <= 200) begin
         i_nib_vld = 1'b0;
         i_instr_rdy = 1'($urandom_range(0, 1));
         step();
         k++;
      end
      if (rnd) begin
         total++;
         assert (k <= 200) else begin
            bad++;
            $error("FAIL nib_wait observed=%0d expected<=200", k);
         end
         i_instr_rdy = 1'($urandom_range(0, 1));
      end
      i_nib_vld = 1'b1;
      i_nib = n;
      step();
      i_nib_vld = 1'b0;
   endtask

   task automatic send_word(input logic [15:0] w, input logic [15:0] imm, input bit push, input bit rnd);
      logic [15:0] v;
      int   n;
      exp_t e;
      n = (w[5:3] == 3'd7) ? 8 : 4;
      if (push) begin
         e.instr = model(w);
         e.imm = (n == 8) ? imm : 16'd0;
         sb.push_back(e);
         pushed++;
      end
      for (int i = 0; i < n; i++) begin
         v = (i < 4) ? w : imm;
         put(v[15-4*(i%4) -: 4], rnd);
      end
   endtask

   task automatic rst_chk(input string tag);
      chk({tag, "_vld"}, 32'(o_instr_vld), 32'd0);
      chk({tag, "_nrdy"}, 32'(o_nib_rdy), 32'd1);
      chk({tag, "_imm"}, 32'(o_imm), 32'd0);
      chk({tag, "_instr"}, 32'(o_instr), 32'd0);
   endtask

   initial begin
      logic [15:0] w;
      int   k;
      // reset
      step();
      step();
      i_rst_n = 1'b1;
      rst_chk("reset");
      // plain decode
      i_instr_rdy = 1'b1;
      send_word(16'h1234, 16'h0, 1, 0);
      chk("plain_vld", 32'(o_instr_vld), 32'd1);
      chk("plain_instr", 32'(o_instr), 32'(K1234));
      chk("plain_imm", 32'(o_imm), 32'd0);
      step();
      chk("plain_vld_drop", 32'(o_instr_vld), 32'd0);
      chk("plain_nrdy", 32'(o_nib_rdy), 32'd1);
      // immediate
      sb.push_back('{instr: model(16'h003A), imm: 16'hBEEF});
      pushed++;
      put(4'h0, 0); put(4'h0, 0); put(4'h3, 0); put(4'hA, 0);
      chk("imm_novld", 32'(o_instr_vld), 32'd0);
      put(4'hB, 0); put(4'hE, 0); put(4'hE, 0); put(4'hF, 0);
      chk("imm_vld", 32'(o_instr_vld), 32'd1);
      chk("imm_c", 32'(o_instr.op_c), 32'd7);
      chk("imm_cimm", 32'(o_instr.op_c_imm), 32'd1);
      chk("imm_q", 32'(o_instr.op_q), 32'd1);
      chk("imm_val", 32'(o_imm), 32'hBEEF);
      step();
      // backpressure
      i_instr_rdy = 1'b0;
      send_word(16'h1234, 16'h0, 1, 0);
      for (int i = 0; i < 6; i++) begin
         i_nib_vld = 1'b1;
         i_nib = 4'h9;
         step();
         chk("bp_vld", 32'(o_instr_vld), 32'd1);
         chk("bp_nrdy", 32'(o_nib_rdy), 32'd0);
         chk("bp_instr", 32'(o_instr), 32'(K1234));
      end
      i_nib_vld = 1'b0;
      i_instr_rdy = 1'b1;
      step();
      chk("bp_release_vld", 32'(o_instr_vld), 32'd0);
      chk("bp_release_nrdy", 32'(o_nib_rdy), 32'd1);
      send_word(16'hABCD, 16'h0, 1, 0);
      chk("bp_fresh", 32'(o_instr), 32'(model(16'hABCD)));
      step();
      // flush after two nibbles
      put(4'h7, 0); put(4'h7, 0);
      i_flush = 1'b1;
      step();
      i_flush = 1'b0;
      rst_chk("flush_instr");
      send_word(16'hABCD, 16'h0, 1, 0);
      chk("flush_instr_clean", 32'(o_instr), 32'(model(16'hABCD)));
      step();
      // flush during IMM
      put(4'h0, 0); put(4'h0, 0); put(4'h3, 0); put(4'hA, 0); put(4'hB, 0); put(4'hE, 0);
      i_flush = 1'b1;
      step();
      i_flush = 1'b0;
      rst_chk("flush_imm");
      send_word(16'h1234, 16'h0, 1, 0);
      chk("flush_imm_clean", 32'(o_instr), 32'(K1234));
      chk("flush_imm_zero", 32'(o_imm), 32'd0);
      step();
      // flush in HOLD with rdy high
      i_instr_rdy = 1'b0;
      send_word(16'h0FF0, 16'h0, 0, 0);
      chk("flush_hold_vld", 32'(o_instr_vld), 32'd1);
      i_instr_rdy = 1'b1;
      i_flush = 1'b1;
      step();
      i_flush = 1'b0;
      rst_chk("flush_hold");
      send_word(16'h4321, 16'h0, 1, 0);
      chk("flush_hold_clean", 32'(o_instr), 32'(model(16'h4321)));
      step();
      // reset in IMM
      put(4'h0, 0); put(4'h0, 0); put(4'h3, 0); put(4'hA, 0); put(4'hB, 0); put(4'hE, 0);
      i_rst_n = 1'b0;
      step();
      i_rst_n = 1'b1;
      rst_chk("rst_mid");
      send_word(16'h1234, 16'h0, 1, 0);
      chk("rst_mid_clean", 32'(o_instr), 32'(K1234));
      step();
      // gapped random stream
      for (int i = 0; i < 100; i++) begin
         w = 16'($urandom);
         if ($urandom_range(0, 1) == 1) w[5:3] = 3'd7;
         send_word(w, 16'($urandom), 1, 1);
      end
      i_instr_rdy = 1'b1;
      k = 0;
      while (sb.size() > 0 && k < 50) begin
         step();
         k++;
      end
      chk("drain_empty", 32'(sb.size()), 32'd0);
      chk("hs_count", 32'(hs), 32'(pushed));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/idli_decode.md
# idli_decode

Front-end decode stage. It sits between the SQI fetch path and the execution unit. It assembles 4-bit nibbles streamed from the SQI memory into a 16-bit instruction word. When the instruction needs one, it collects a trailing 16-bit immediate. It then presents a fully decoded `idli_pkg::instr_t` plus immediate to the execution unit over a valid/ready handshake.

## Interface
Parameters: none. Encoding and types come from `idli_pkg`.

- `i_clk` in 1: clock. One clock for the whole block.
- `i_rst_n` in 1: reset, synchronous, active-low.
- `i_nib_vld` in 1: `i_nib` carries a fetched nibble this cycle.
- `i_nib` in 4: nibble from SQI, most-significant nibble of each 16-bit word first.
- `o_nib_rdy` out 1: decoder accepts a nibble this cycle. A transfer happens when `i_nib_vld && o_nib_rdy`.
- `i_flush` in 1: discard all partial and held state (redirect/branch).
- `o_instr_vld` out 1: `o_instr`/`o_imm` hold a complete decoded instruction.
- `i_instr_rdy` in 1: execution unit consumes the instruction this cycle.
- `o_instr` out `instr_t` (18 bits): decoded instruction.
- `o_imm` out 16: immediate. Valid only when `o_instr.op_c_imm`, otherwise 0.

## Operation
- Instruction word encoding (bit 15 = first nibble's MSB):
  - `[15:14]` `op_p`
  - `[13:12]` `alu_op`
  - `[11:9]` `op_a`
  - `[8:6]` `op_b`
  - `[5:3]` `op_c`
  - `[2:1]` `op_q`
  - `[0]` dst select
- Derived fields:
  - `op_a_wr_en = ~w[0]`
  - `op_q_wr_en = w[0]`
  - `op_c_imm = (op_c == GREG_PC)`. C field 7 means "take immediate".
- State machine with 3 states and a 2-bit nibble counter `cnt`:
  - INSTR: shift each accepted nibble into word register (`w <= {w[11:0], i_nib}`), `cnt++`. On the 4th nibble (`cnt==3`), if C field of the completed word is 7, go to IMM with `cnt=0`; else go to HOLD.
  - IMM: shift accepted nibbles into `imm`, `cnt++`. On the 4th nibble, go to HOLD.
  - HOLD: `o_instr_vld=1`, `o_nib_rdy=0`. On `i_instr_rdy`, go to INSTR with `cnt=0`, and clear `imm` to 0.
- `o_nib_rdy = (state != HOLD)`. Combinational from state; does not depend on `i_nib_vld`.
- No nibble is accepted while in HOLD. Fetch must stall.
- `o_instr` is decoded combinationally from the word register. It is stable throughout HOLD.
- `i_flush` has highest priority:
  - next state INSTR, `cnt=0`, `imm=0`, `o_instr_vld=0`.
  - A nibble presented in the same cycle is dropped.
  - A held instruction is dropped even if `i_instr_rdy` is high.
- Reset (`!i_rst_n` at clock edge): identical to flush, and the word register is cleared. The output values listed under Timing apply from the first cycle after reset.
- `cnt` is 2 bits and wraps 3->0 on the completing nibble. No other width extension exists.
- Idle cycles (`i_nib_vld=0`) in INSTR/IMM hold all state. Gaps between nibbles are allowed anywhere.

## Timing
- Reset/flush outputs: `o_instr_vld=0`, `o_nib_rdy=1`, `o_imm=0`, `o_instr=0`.
- Latency: `o_instr_vld` rises the cycle after the final nibble (4th for a plain instruction, 8th for an immediate instruction) is accepted.
- Minimum issue interval with back-to-back nibbles and `i_instr_rdy` held high:
  - 5 cycles per plain instruction.
  - 9 cycles per immediate instruction.
- Handshake: transfer when `o_instr_vld && i_instr_rdy`. The next cycle `o_instr_vld=0` and `o_nib_rdy=1`. There is no same-cycle refill.
- `i_instr_rdy` while `o_instr_vld=0` is ignored.
- `o_instr_vld` never drops without a handshake, flush or reset.

## Test plan
- Plain decode:
  - Stimulus: reset, then nibbles 1,2,3,4 on consecutive cycles, rdy=1.
  - Response: vld on cycle 5 with `p=0`, `alu=AND`, `a=1`, `b=0`, `c=6`, `q=2`, `a_wr=1`, `q_wr=0`, `c_imm=0`, `imm=0`. vld low the next cycle.
- Immediate:
  - Stimulus: nibbles 0,0,3,A then B,E,E,F.
  - Response: no vld after the 4th nibble. vld after the 8th with `c=7`, `c_imm=1`, `q=1`, `imm=0xBEEF`.
- Backpressure:
  - Stimulus: complete 0x1234 with rdy=0 for 6 cycles.
  - Response: vld and `o_instr` stable, `o_nib_rdy=0`, extra nibbles ignored. On rdy=1 there is one handshake, and the next nibbles start a fresh word.
- Flush:
  - Stimulus: flush after 2 nibbles, during IMM, and in HOLD with rdy=1 in the same cycle.
  - Response: vld=0, nib_rdy=1 next cycle. Next 4 nibbles decode as a clean word with no residue from the flushed one.
- Reset mid-operation:
  - Stimulus: assert `i_rst_n=0` for one cycle while in IMM with 2 immediate nibbles taken.
  - Response: all outputs at reset values. Subsequent 0x1234 decodes correctly.
- Gapped stream:
  - Stimulus: random `i_nib_vld` gaps across 100 random words against a reference model.
  - Response: every decoded word/imm matches the model, in order, none lost or duplicated.
